// File: rtl/pipe_stage_pkg.sv
// Shared constants for the pipeline stage register: FSM state encoding,
// occupancy counter width and a state-to-occupancy decode helper.
package pipe_stage_pkg;

    localparam int COUNT_W = 2;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // Number of entries held in a given state; the unused code reads as empty.
    function automatic logic [COUNT_W-1:0] state_count(input logic [1:0] st);
        logic [COUNT_W-1:0] cnt;
        case (st)
            ST_EMPTY: cnt = 2'd0;
            ST_ONE:   cnt = 2'd1;
            ST_FULL:  cnt = 2'd2;
            default:  cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with load enable and asynchronous active-low reset.
// Holds its value whenever LOAD is low, so idle stages do not toggle.
module pipe_data_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Capture D on LOAD, otherwise retain the stored word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= RESET_VALUE;
        end else if (LOAD) begin
            Q <= D;
        end else begin
            Q <= Q;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer. With SKID=1 IN_READY comes from a flop
// so the downstream ready path is cut; with SKID=0 the stage is a single
// register whose IN_READY is derived combinationally from OUT_READY.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit               SKID        = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               FLUSH,
    input  logic [WIDTH-1:0]   IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [COUNT_W-1:0] COUNT
);

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic               out_valid_r;
    logic [COUNT_W-1:0] count_r;
    logic               in_ready_r;
    logic               in_ready_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               head_load_s;
    logic               skid_load_s;
    logic [WIDTH-1:0]   head_d_s;
    logic [WIDTH-1:0]   head_q_s;
    logic [WIDTH-1:0]   skid_q_s;

    // Upstream ready: a flop in skid mode, otherwise "empty or draining".
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready_s = in_ready_r;
        end else begin : g_ready_comb
            assign in_ready_s = ~out_valid_r | OUT_READY;
        end
    endgenerate

    assign in_fire_s  = IN_VALID & in_ready_s;
    assign out_fire_s = out_valid_r & OUT_READY;

    // Next state and register load strobes. FLUSH empties the stage and
    // suppresses every load so a killed entry never reaches OUT_DATA.
    // Without a skid register the ONE state can only see in_fire together
    // with out_fire (IN_READY needs OUT_READY), so FULL is never entered.
    always_comb begin
        state_nxt_s = state_r;
        head_load_s = 1'b0;
        skid_load_s = 1'b0;
        if (FLUSH) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        head_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (in_fire_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        head_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Head refills from the skid entry when draining FULL, else from upstream.
    always_comb begin
        if (state_r == ST_FULL) begin
            head_d_s = skid_q_s;
        end else begin
            head_d_s = IN_DATA;
        end
    end

    // State plus registered OUT_VALID, COUNT and IN_READY, all decoded from
    // the next state so they change together on the clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            count_r     <= state_count(state_nxt_s);
            in_ready_r  <= (state_nxt_s != ST_FULL);
        end
    end

    pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_head (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (head_load_s),
        .D     (head_d_s),
        .Q     (head_q_s)
    );

    generate
        if (SKID) begin : g_skid
            pipe_data_reg #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid (
                .CLK   (CLK),
                .RST_N (RST_N),
                .LOAD  (skid_load_s),
                .D     (IN_DATA),
                .Q     (skid_q_s)
            );
        end else begin : g_no_skid
            assign skid_q_s = RESET_VALUE;
        end
    endgenerate

    assign IN_READY  = in_ready_s;
    assign OUT_DATA  = head_q_s;
    assign OUT_VALID = out_valid_r;
    assign COUNT     = count_r;

endmodule
